// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// arbiter state encoding and bus widths.
package sdram_pkg;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 12;
  localparam int DQ_W   = 16;
  localparam int CMD_W  = 4;

  localparam logic [CMD_W-1:0] C_NOP         = 4'b0111;
  localparam logic [CMD_W-1:0] C_PRECHARGE   = 4'b0010;
  localparam logic [CMD_W-1:0] C_AUTOREFRESH = 4'b0001;
  localparam logic [CMD_W-1:0] C_ACTIVE      = 4'b0011;
  localparam logic [CMD_W-1:0] C_READ        = 4'b0101;
  localparam logic [CMD_W-1:0] C_WRITE       = 4'b0100;
  localparam logic [CMD_W-1:0] C_MRS         = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
  } cmd_bus_t;
endpackage

// File: rtl/sdram_cmd_mux.sv
// Selects the SDRAM command/address/data source from the arbiter state;
// holds the pins at NOP/idle while force_idle (reset) is high.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter logic [3:0] CMD_NOP = C_NOP
) (
  input  logic        force_idle,
  input  logic [2:0]  state,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic [3:0]  ar_cmd,
  input  logic [1:0]  ar_ba,
  input  logic [11:0] ar_addr,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_sdram_en,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe
);
  cmd_bus_t   sel;
  arb_state_t st;

  assign st = arb_state_t'(state);

  always_comb begin
    sel         = '{cmd: CMD_NOP, ba: '1, addr: '1};
    sdram_dq_oe = 1'b0;
    if (!force_idle) begin
      case (st)
        ST_INIT:  sel = '{cmd: init_cmd, ba: init_ba, addr: init_addr};
        ST_AREF:  sel = '{cmd: ar_cmd,   ba: ar_ba,   addr: ar_addr};
        ST_WRITE: begin
          sel         = '{cmd: wr_cmd, ba: wr_ba, addr: wr_addr};
          sdram_dq_oe = wr_sdram_en;
        end
        ST_READ:  sel = '{cmd: rd_cmd,   ba: rd_ba,   addr: rd_addr};
        default:  ;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel.cmd;
  assign sdram_ba   = sel.ba;
  assign sdram_addr = sel.addr;
  assign sdram_dq_o = wr_data;
  assign sdram_cke  = ~force_idle;
endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: init -> arbitrate among refresh/write/read with
// refresh priority, write/read round-robin and a grant watchdog.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter logic [9:0] TIMEOUT_MAX = 10'd1000,
  parameter logic [3:0] CMD_NOP     = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        ar_req,
  input  logic        ar_end,
  input  logic [3:0]  ar_cmd,
  input  logic [1:0]  ar_ba,
  input  logic [11:0] ar_addr,
  output logic        ar_en,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_sdram_en,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic        timeout_err
);
  arb_state_t state, nxt;
  logic       last_grant;
  logic [9:0] wd_cnt;
  logic       in_grant, cur_end, tmo, expire;

  // Grant lasts at most TIMEOUT_MAX cycles: the counter reads TIMEOUT_MAX-1
  // in the last allowed cycle. An *_end in that same cycle wins.
  assign in_grant = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);
  assign tmo      = (wd_cnt == TIMEOUT_MAX - 10'd1);
  assign expire   = in_grant && !cur_end && tmo;

  always_comb begin
    cur_end = 1'b0;
    nxt     = state;
    case (state)
      ST_INIT:  if (init_done) nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (ar_req)                nxt = ST_AREF;
        else if (wr_req && rd_req) nxt = last_grant ? ST_WRITE : ST_READ;
        else if (wr_req)           nxt = ST_WRITE;
        else if (rd_req)           nxt = ST_READ;
      end
      ST_AREF: begin
        cur_end = ar_end;
        if (ar_end || tmo) nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        cur_end = wr_end;
        if (wr_end || tmo) nxt = ST_ARBIT;
      end
      ST_READ: begin
        cur_end = rd_end;
        if (rd_end || tmo) nxt = ST_ARBIT;
      end
      default: nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_INIT;
      last_grant  <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_ARBIT && nxt == ST_WRITE) last_grant <= 1'b0;
      if (state == ST_ARBIT && nxt == ST_READ)  last_grant <= 1'b1;
      wd_cnt <= in_grant ? wd_cnt + 10'd1 : '0;
      if (expire) timeout_err <= 1'b1;
    end
  end

  // Grants drop in the reset cycle itself, before the state register clears.
  assign ar_en = (state == ST_AREF)  && !ar_end && !sys_rst;
  assign wr_en = (state == ST_WRITE) && !wr_end && !sys_rst;
  assign rd_en = (state == ST_READ)  && !rd_end && !sys_rst;

  sdram_cmd_mux #(.CMD_NOP(CMD_NOP)) u_mux (
    .force_idle  (sys_rst),
    .state       (state),
    .init_cmd    (init_cmd),
    .init_ba     (init_ba),
    .init_addr   (init_addr),
    .ar_cmd      (ar_cmd),
    .ar_ba       (ar_ba),
    .ar_addr     (ar_addr),
    .wr_cmd      (wr_cmd),
    .wr_ba       (wr_ba),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_sdram_en (wr_sdram_en),
    .rd_cmd      (rd_cmd),
    .rd_ba       (rd_ba),
    .rd_addr     (rd_addr),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_ba    (sdram_ba),
    .sdram_addr  (sdram_addr),
    .sdram_dq_o  (sdram_dq_o),
    .sdram_dq_oe (sdram_dq_oe)
  );
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init handoff, priority, round-robin,
// no preemption, watchdog timeout and reset abort.
module tb_sdram_arbiter;
  localparam int TMO = 20;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_done;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [11:0] init_addr;
  logic        ar_req, ar_end, ar_en;
  logic [3:0]  ar_cmd;
  logic [1:0]  ar_ba;
  logic [11:0] ar_addr;
  logic        wr_req, wr_end, wr_en, wr_sdram_en;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req, rd_end, rd_en;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [11:0] rd_addr;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe, timeout_err;
  logic [3:0]  cmd;

  int checks = 0;
  int errors = 0;

  assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  always #5 sys_clk = ~sys_clk;

  sdram_arbiter #(.TIMEOUT_MAX(10'(TMO)), .CMD_NOP(4'b0111)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_ba(ar_ba),
    .ar_addr(ar_addr), .ar_en(ar_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_sdram_en(wr_sdram_en), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd"},  32'(cmd),        32'h7);
    chk({tag, "_ba"},   32'(sdram_ba),   32'h3);
    chk({tag, "_addr"}, 32'(sdram_addr), 32'hfff);
  endtask

  initial begin
    sys_rst = 1'b1; init_done = 1'b0;
    init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 12'h400;
    ar_req = 1'b1; ar_end = 1'b0; ar_cmd = 4'b0001; ar_ba = 2'b10; ar_addr = 12'h123;
    wr_req = 1'b1; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b01; wr_addr = 12'h0a5;
    wr_data = 16'hbeef; wr_sdram_en = 1'b1;
    rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b11; rd_addr = 12'h05a;

    // Reset: pins idle, cke low, no grants even with requests pending
    repeat (3) tick();
    #1;
    chk_idle("rst");
    chk("rst_cke", 32'(sdram_cke), 0);
    chk("rst_oe", 32'(sdram_dq_oe), 0);
    chk("rst_grants", 32'({ar_en, wr_en, rd_en}), 0);
    chk("rst_terr", 32'(timeout_err), 0);

    // INIT passes init_* through and ignores requests until init_done at cycle 10
    sys_rst = 1'b0;
    #1;
    chk("init_cke", 32'(sdram_cke), 1);
    for (int c = 1; c < 10; c++) begin
      chk("init_cmd", 32'(cmd), 32'h2);
      chk("init_grants", 32'({ar_en, wr_en, rd_en}), 0);
      tick();
    end
    chk("init_ba", 32'(sdram_ba), 32'h1);
    chk("init_addr", 32'(sdram_addr), 32'h400);
    init_done = 1'b1; ar_req = 1'b0; wr_req = 1'b0;
    #1;
    chk("init_c10_cmd", 32'(cmd), 32'h2);
    tick();
    init_done = 1'b0;
    #1;
    chk_idle("arbit_c11");
    chk("arbit_grants", 32'({ar_en, wr_en, rd_en}), 0);

    // Refresh beats write when both request together
    ar_req = 1'b1; wr_req = 1'b1;
    #1;
    chk("prio_arbit_ar_en", 32'(ar_en), 0);
    tick();
    ar_req = 1'b0;
    #1;
    chk("prio_ar_en", 32'(ar_en), 1);
    chk("prio_wr_en", 32'(wr_en), 0);
    chk("aref_cmd", 32'(cmd), 32'h1);
    chk("aref_ba", 32'(sdram_ba), 32'h2);
    chk("aref_addr", 32'(sdram_addr), 32'h123);
    tick();
    ar_end = 1'b1;
    #1;
    chk("aref_end_drops_en", 32'(ar_en), 0);
    chk("aref_end_cmd", 32'(cmd), 32'h1);
    tick();
    ar_end = 1'b0;
    #1;
    chk("after_aref_wr_en", 32'(wr_en), 0);
    chk_idle("after_aref");
    tick();
    #1;
    chk("wr_en", 32'(wr_en), 1);
    chk("wr_cmd", 32'(cmd), 32'h4);
    chk("wr_ba", 32'(sdram_ba), 32'h1);
    chk("wr_addr", 32'(sdram_addr), 32'h0a5);
    chk("wr_oe", 32'(sdram_dq_oe), 1);
    chk("wr_dq", 32'(sdram_dq_o), 32'hbeef);

    // ar_req mid-write waits; stray ar_end during WRITE is ignored
    wr_req = 1'b0; ar_req = 1'b1; ar_end = 1'b1;
    tick();
    ar_end = 1'b0;
    #1;
    chk("nopre_wr_en1", 32'(wr_en), 1);
    chk("nopre_ar_en1", 32'(ar_en), 0);
    tick();
    #1;
    chk("nopre_wr_en2", 32'(wr_en), 1);
    chk("nopre_ar_en2", 32'(ar_en), 0);
    tick();
    wr_end = 1'b1;
    #1;
    chk("wr_end_drops_en", 32'(wr_en), 0);
    tick();
    wr_end = 1'b0;
    #1;
    chk_idle("after_wr");
    chk("after_wr_ar_en", 32'(ar_en), 0);
    tick();
    ar_req = 1'b0;
    #1;
    chk("pending_aref_en", 32'(ar_en), 1);
    ar_end = 1'b1;
    tick();
    ar_end = 1'b0;
    #1;
    chk_idle("after_aref2");

    // Single read: sets last_grant=1; dq stays tristated despite wr_sdram_en
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    #1;
    chk("rd_en", 32'(rd_en), 1);
    chk("rd_cmd", 32'(cmd), 32'h5);
    chk("rd_ba", 32'(sdram_ba), 32'h3);
    chk("rd_addr", 32'(sdram_addr), 32'h05a);
    chk("rd_oe", 32'(sdram_dq_oe), 0);
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    #1;
    chk_idle("after_rd");

    // Both held: alternation W,R,W,R since last grant was a read
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      #1;
      chk("rr_wr_en", 32'(wr_en), (g % 2 == 0) ? 1 : 0);
      chk("rr_rd_en", 32'(rd_en), (g % 2 == 0) ? 0 : 1);
      if (g % 2 == 0) wr_end = 1'b1;
      else            rd_end = 1'b1;
      tick();
      wr_end = 1'b0; rd_end = 1'b0;
      #1;
      chk("rr_arbit_cmd", 32'(cmd), 32'h7);
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Watchdog: read never ends, grant lasts exactly TMO cycles
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    #1;
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_rd_en", 32'(rd_en), 1);
      chk("tmo_terr_low", 32'(timeout_err), 0);
      tick();
      #1;
    end
    chk("tmo_rd_en_off", 32'(rd_en), 0);
    chk("tmo_terr_set", 32'(timeout_err), 1);
    chk_idle("tmo_arbit");
    repeat (3) tick();
    #1;
    chk("tmo_terr_sticky", 32'(timeout_err), 1);

    // Reset mid-write aborts the grant in the same cycle
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    #1;
    chk("pre_rst_wr_en", 32'(wr_en), 1);
    chk("pre_rst_oe", 32'(sdram_dq_oe), 1);
    sys_rst = 1'b1;
    #1;
    chk("rst_mid_oe", 32'(sdram_dq_oe), 0);
    chk("rst_mid_wr_en", 32'(wr_en), 0);
    chk("rst_mid_cke", 32'(sdram_cke), 0);
    chk_idle("rst_mid");
    tick();
    sys_rst = 1'b0; wr_req = 1'b1;
    #1;
    chk("post_rst_terr", 32'(timeout_err), 0);
    chk("post_rst_init_cmd", 32'(cmd), 32'h2);
    chk("post_rst_wr_en", 32'(wr_en), 0);
    tick();
    #1;
    chk("post_rst_still_init", 32'(cmd), 32'h2);
    chk("post_rst_no_grant", 32'({ar_en, wr_en, rd_en}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
